// File: rtl/full_adder.sv
`timescale 1ns/1ps
// Purpose: registered WIDTH-bit ripple-carry adder, {cout,sum} = a + b + cin (signed ovf with FA_OVERFLOW_EN).
// Latency: 1 cycle from in_valid to out_valid; sum/cout/ovf hold between captures.
// Backpressure: none; a new operand set is accepted every cycle.

// Purpose: 1-bit full-adder cell.
// Latency: combinational.
// Backpressure: n/a.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// Purpose: WIDTH-bit registered adder top; macro FA_OVERFLOW_EN adds the ovf output.
// Latency: 1 cycle.
// Backpressure: none.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             out_valid
`ifdef FA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("full_adder: WIDTH must be in 1..64");
    end

    // Operands are forced to zero when not valid so X never reaches the carry chain.
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic             cin_m;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign a_m   = in_valid ? a   : '0;
    assign b_m   = in_valid ? b   : '0;
    assign cin_m = in_valid ? cin : 1'b0;
    assign c[0]  = cin_m;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a_m[i]),
            .b  (b_m[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef FA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= s;
                cout <= c[WIDTH];
`ifdef FA_OVERFLOW_EN
                ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
            end
        end
    end
endmodule

// File: tb/tb_full_adder.sv
`timescale 1ns/1ps
module tb_full_adder;
    logic       clk;
    logic       rst_n;
    logic       a1, b1, cin1, iv1, c1, vld1;
    logic [0:0] s1;
    logic [7:0] a8, b8, s8;
    logic       cin8, iv8, c8, vld8;
`ifdef FA_OVERFLOW_EN
    logic       ov1, ov8;
`endif
    int n_checks;
    int n_fail;
    logic [1:0] tbl [8];

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .cout(c1), .sum(s1), .a(a1), .b(b1),
        .cin(cin1), .in_valid(iv1), .out_valid(vld1)
`ifdef FA_OVERFLOW_EN
        , .ovf(ov1)
`endif
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .cout(c8), .sum(s8), .a(a8), .b(b8),
        .cin(cin8), .in_valid(iv8), .out_valid(vld8)
`ifdef FA_OVERFLOW_EN
        , .ovf(ov8)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signed overflow: the exact signed result does not fit in w bits.
    function automatic logic ovf_ref(input int w, input int sa, input int sb, input int ci);
        int r;
        r = sa + sb + ci;
        return (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
    endfunction

    logic [7:0] pa [4];
    logic [7:0] pb [4];
    logic [7:0] ps [4];
    logic       pc [4];
    logic       e1v, e1c, e8v, e8c, e1o, e8o;
    logic [0:0] e1s;
    logic [7:0] e8s;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        pa = '{8'd1, 8'd3, 8'd200, 8'd0};
        pb = '{8'd2, 8'd4, 8'd100, 8'd0};
        ps = '{8'd3, 8'd7, 8'd44, 8'd0};
        pc = '{1'b0, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b1;
        {a1, b1, cin1, iv1} = '0;
        {a8, b8, cin8, iv8} = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #3;
        chk("rst_w1", {vld1, c1, s1}, 64'd0);
        chk("rst_w8", {vld8, c8, s8}, 64'd0);
`ifdef FA_OVERFLOW_EN
        chk("rst_ovf", {ov1, ov8}, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive WIDTH=1
        for (int v = 0; v < 8; v++) begin
            {cin1, a1, b1} = 3'(v);
            iv1 = 1'b1;
            tick();
            chk($sformatf("exh%0d", v), {vld1, c1, s1}, {1'b1, tbl[v]});
`ifdef FA_OVERFLOW_EN
            chk($sformatf("exh_ovf%0d", v), 64'(ov1),
                64'(ovf_ref(1, a1 ? -1 : 0, b1 ? -1 : 0, int'(cin1))));
`endif
        end

        // Hold with X operands while idle
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; iv1 = 1'b1;
        tick();
        chk("hold_cap", {vld1, c1, s1}, 64'b110);
        iv1 = 1'b0; a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold%0d", k), {vld1, c1, s1}, 64'b010);
        end

        // Asynchronous reset mid-operation discards the in-flight result
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
        #5 rst_n = 1'b0;
        #1;
        chk("arst_imm", {vld1, c1, s1}, 64'd0);
        tick();
        chk("arst_held", {vld1, c1, s1}, 64'd0);
`ifdef FA_OVERFLOW_EN
        chk("arst_ovf", 64'(ov1), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        tick();
        chk("arst_release", {vld1, c1, s1}, 64'b110);
        iv1 = 1'b0;

        // WIDTH=8 wrap and signed overflow
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; iv8 = 1'b1;
        tick();
        chk("w8_wrap", {vld8, c8, s8}, {1'b1, 1'b1, 8'h00});
`ifdef FA_OVERFLOW_EN
        chk("w8_wrap_ovf", 64'(ov8), 64'd0);
`endif
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        tick();
        chk("w8_7f", {vld8, c8, s8}, {1'b1, 1'b0, 8'h80});
`ifdef FA_OVERFLOW_EN
        chk("w8_7f_ovf", 64'(ov8), 64'd1);
`endif
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        chk("w8_allones", {vld8, c8, s8}, {1'b1, 1'b1, 8'hFF});

        // Back-to-back operands, one per cycle
        for (int k = 0; k < 4; k++) begin
            a8 = pa[k]; b8 = pb[k]; cin8 = 1'b0; iv8 = 1'b1;
            tick();
            chk($sformatf("b2b%0d", k), {vld8, c8, s8}, {1'b1, pc[k], ps[k]});
        end

        // Random traffic against an arithmetic reference
        {e1v, e1c, e1o, e8v, e8c, e8o} = '0;
        e1s = '0;
        e8s = '0;
        for (int n = 0; n < 300; n++) begin
            iv1 = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            iv8 = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (iv1) begin
                a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
                {e1c, e1s} = 2'(a1) + 2'(b1) + 2'(cin1);
                e1o = ovf_ref(1, a1 ? -1 : 0, b1 ? -1 : 0, int'(cin1));
            end else begin
                a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
            end
            if (iv8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                {e8c, e8s} = 9'(a8) + 9'(b8) + 9'(cin8);
                e8o = ovf_ref(8, int'($signed(a8)), int'($signed(b8)), int'(cin8));
            end else begin
                a8 = 'x; b8 = 'x; cin8 = 1'bx;
            end
            e1v = iv1;
            e8v = iv8;
            tick();
            chk($sformatf("rnd_w1_%0d", n), {vld1, c1, s1}, {e1v, e1c, e1s});
            chk($sformatf("rnd_w8_%0d", n), {vld8, c8, s8}, {e8v, e8c, e8s});
`ifdef FA_OVERFLOW_EN
            chk($sformatf("rnd_ovf_%0d", n), {ov1, ov8}, {e1o, e8o});
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
